elastic_mem_responder: RTL and testbench
========================================

ELASTIC_MEM_RESPONDER -- requirements
Module: elastic_mem_responder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width of writedata and memdata.
REQ-002 The block SHALL have parameter ADRBITS, default 8, giving the address width; memory depth is 2**ADRBITS words.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port adr, input, ADRBITS bits: request address.
REQ-006 The block SHALL have port writedata, input, WIDTH bits: store data.
REQ-007 The block SHALL have port memread, input, 1 bit: the request is a read.
REQ-008 The block SHALL have port memwrite, input, 1 bit: the request is a write.
REQ-009 The block SHALL have port VY, input, 1 bit: request channel valid.
REQ-010 The block SHALL have port SY, output, 1 bit: request channel stop.
REQ-011 The block SHALL have port memdata, output, WIDTH bits: response data.
REQ-012 The block SHALL have port VX, output, 1 bit: response channel valid.
REQ-013 The block SHALL have port SX, input, 1 bit: response channel stop.

Function
REQ-014 Both channels SHALL use valid/stop elastic handshakes; a token transfers on a rising edge where valid=1 and stop=0.
REQ-015 A request is accepted when VY=1 and SY=0; it is ignored otherwise, including its memwrite.
REQ-016 Each accepted request SHALL produce exactly one response token, in acceptance order, for reads, writes and requests with memread=memwrite=0 alike.
REQ-017 Response data SHALL be RAM[adr] when memread=1 and 0 otherwise, sampled in the acceptance cycle.
REQ-018 An accepted request with memwrite=1 SHALL write writedata to RAM[adr] at that rising edge.
REQ-019 memread=1 and memwrite=1 together: the write SHALL occur and the response SHALL carry the pre-write data.
REQ-020 Responses SHALL be held in a 2-entry FIFO, main and auxiliary slots, with occupancy count 0..2.
REQ-021 Latency: a response SHALL appear on VX/memdata the cycle after acceptance when the FIFO was empty.
REQ-022 SY SHALL be 1 exactly when count=2, decoded from registered state only, with no combinational path from VY or SX.
REQ-023 VX SHALL be 1 exactly when count>=1; memdata SHALL show the oldest entry, and 0 when count=0.
REQ-024 Persistence: while VX=1 and SX=1, VX and memdata SHALL be held unchanged.
REQ-025 Count update: accept only -> +1; response transfer only -> -1; both in the same cycle -> unchanged, head advances and the new entry is appended.
REQ-026 At count=1 with VY=1 and SX=0 held, the block SHALL sustain one transfer per cycle on both channels.
REQ-027 At count=2, no request SHALL be accepted; a response transfer reduces count to 1, and SY falls the next cycle.
REQ-028 Address arithmetic SHALL be unsigned with no wrap or bounds logic; every ADRBITS value addresses a valid word.

Reset
REQ-029 On reset=1 at a rising edge: count=0, VX=0, SY=0, memdata=0, and any pending responses SHALL be discarded.
REQ-030 Reset SHALL NOT clear RAM contents; writes accepted before reset SHALL persist.
REQ-031 While reset=1, no request SHALL be accepted and no RAM write SHALL occur, regardless of VY or memwrite.
REQ-032 Reset asserted mid-stream with count=2 and SX=1 SHALL yield VX=0 and SY=0 in the following cycle.

Verification
REQ-033 Write then read: accept write adr=8'h10, writedata=8'hA5, then read adr=8'h10 with SX=0 -> two responses, 8'h00 then 8'hA5, each one cycle after its acceptance.
REQ-034 Back-pressure fill: SX=1, three consecutive reads of 8'h01, 8'h02, 8'h03 held valid -> first two accepted, SY=1, VX=1 with data RAM[8'h01] held; release SX -> responses arrive in order and the third read is then accepted.
REQ-035 Read-modify-write: RAM[8'h20]=8'h11, accept memread=memwrite=1, adr=8'h20, writedata=8'h22 -> response 8'h11; a later read returns 8'h22.
REQ-036 Streaming: 16 reads at consecutive addresses, VY=1 and SX=0 held -> 16 responses on 16 consecutive cycles, SY=0 throughout.
REQ-037 Reset mid-operation: count=2 and SX=1, pulse reset for one cycle -> VX=0, SY=0, memdata=0; the RAM word written before reset reads back unchanged.
REQ-038 Ignored write: VY=1, SY=1, memwrite=1, adr=8'h30, writedata=8'hFF -> RAM[8'h30] unchanged on a later read.

Source files
------------

// File: rtl/elastic_mem_responder.sv
// elastic_mem_responder: single-port RAM behind a valid/stop request channel.
// Each accepted request yields one response token, queued in a 2-entry FIFO
// (main = head, aux = second) that drives the valid/stop response channel.
module elastic_mem_responder #(
    parameter int WIDTH   = 8,
    parameter int ADRBITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADRBITS-1:0] adr,
    input  logic [WIDTH-1:0]   writedata,
    input  logic               memread,
    input  logic               memwrite,
    input  logic               VY,
    output logic               SY,
    output logic [WIDTH-1:0]   memdata,
    output logic               VX,
    input  logic               SX
);

    localparam int DEPTH = 1 << ADRBITS;

    logic [WIDTH-1:0] ram_q [0:DEPTH-1];

    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] aux_q, aux_d;

    logic             accept;
    logic             pop;
    logic [WIDTH-1:0] rdata;

    // Stop and valid are decoded purely from the registered occupancy.
    assign SY      = (count_q == 2'd2);
    assign VX      = (count_q != 2'd0);
    assign memdata = VX ? main_q : '0;

    // Reset blocks acceptance so neither a write nor a response can sneak in.
    assign accept = VY && !SY && !reset;
    assign pop    = VX && !SX;

    // Read data is taken before the edge, so a read+write returns the old word.
    assign rdata  = memread ? ram_q[adr] : '0;

    // FIFO next-state: append at the tail, advance head on a response transfer.
    always_comb begin
        count_d = count_q;
        main_d  = main_q;
        aux_d   = aux_q;
        case ({accept, pop})
            2'b10: begin
                count_d = count_q + 2'd1;
                if (count_q == 2'd0) main_d = rdata;
                else                 aux_d  = rdata;
            end
            2'b01: begin
                count_d = count_q - 2'd1;
                main_d  = aux_q;
            end
            2'b11: begin
                // Only reachable at count=1 (accept needs count<2): the head
                // leaves and the new entry becomes the head.
                main_d = rdata;
            end
            default: ;
        endcase
    end

    // FIFO state registers; reset discards any pending responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 2'd0;
            main_q  <= '0;
            aux_q   <= '0;
        end else begin
            count_q <= count_d;
            main_q  <= main_d;
            aux_q   <= aux_d;
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && memwrite) ram_q[adr] <= writedata;
    end

endmodule

// File: tb/tb_elastic_mem_responder.sv
// Directed bench for elastic_mem_responder with hand-computed expectations.
module tb_elastic_mem_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] adr;
    logic [7:0] writedata;
    logic       memread;
    logic       memwrite;
    logic       VY;
    logic       SY;
    logic [7:0] memdata;
    logic       VX;
    logic       SX;

    int n_chk  = 0;
    int n_pass = 0;

    elastic_mem_responder #(.WIDTH(8), .ADRBITS(8)) dut (
        .clk(clk), .reset(reset), .adr(adr), .writedata(writedata),
        .memread(memread), .memwrite(memwrite), .VY(VY), .SY(SY),
        .memdata(memdata), .VX(VX), .SX(SX)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v, input logic rd, input logic wr,
                       input logic [7:0] a, input logic [7:0] d);
        VY = v; memread = rd; memwrite = wr; adr = a; writedata = d;
    endtask

    initial begin
        reset = 1'b1; SX = 1'b0;
        req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        step(); step();
        chk("rst_vx", VX, 0);
        chk("rst_sy", SY, 0);
        chk("rst_data", memdata, 0);
        reset = 1'b0;

        // write then read
        req(1'b1, 1'b0, 1'b1, 8'h10, 8'hA5);
        step();
        chk("wr_vx", VX, 1);
        chk("wr_data", memdata, 8'h00);
        req(1'b1, 1'b1, 1'b0, 8'h10, 8'h00);
        step();
        chk("rd_vx", VX, 1);
        chk("rd_data", memdata, 8'hA5);
        req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
        chk("drain_vx", VX, 0);

        // preload 01..03 and 30
        req(1'b1, 1'b0, 1'b1, 8'h01, 8'h31); step();
        req(1'b1, 1'b0, 1'b1, 8'h02, 8'h32); step();
        req(1'b1, 1'b0, 1'b1, 8'h03, 8'h33); step();
        req(1'b1, 1'b0, 1'b1, 8'h30, 8'h3C); step();
        req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00); step();
        chk("pre_vx", VX, 0);

        // back-pressure fill
        SX = 1'b1;
        req(1'b1, 1'b1, 1'b0, 8'h01, 8'h00); step();
        chk("bp1_vx", VX, 1);
        chk("bp1_sy", SY, 0);
        chk("bp1_data", memdata, 8'h31);
        req(1'b1, 1'b1, 1'b0, 8'h02, 8'h00); step();
        chk("bp2_sy", SY, 1);
        chk("bp2_data", memdata, 8'h31);
        req(1'b1, 1'b1, 1'b0, 8'h03, 8'h00); step();
        chk("bp3_sy", SY, 1);
        chk("bp3_vx", VX, 1);
        chk("bp3_data", memdata, 8'h31);
        SX = 1'b0; step();
        chk("rel1_data", memdata, 8'h32);
        chk("rel1_sy", SY, 0);
        step();
        chk("rel2_vx", VX, 1);
        chk("rel2_data", memdata, 8'h33);
        req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00); step();
        chk("rel3_vx", VX, 0);

        // read-modify-write
        req(1'b1, 1'b0, 1'b1, 8'h20, 8'h11); step();
        req(1'b1, 1'b1, 1'b1, 8'h20, 8'h22); step();
        chk("rmw_data", memdata, 8'h11);
        req(1'b1, 1'b1, 1'b0, 8'h20, 8'h00); step();
        chk("rmw_rd", memdata, 8'h22);
        req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00); step();

        // streaming: fill 16 words, then read them back back-to-back
        for (int i = 0; i < 16; i++) begin
            req(1'b1, 1'b0, 1'b1, 8'(8'h40 + i), 8'(8'h80 + i)); step();
        end
        for (int i = 0; i < 16; i++) begin
            req(1'b1, 1'b1, 1'b0, 8'(8'h40 + i), 8'h00); step();
            chk($sformatf("st%0d_vx", i), VX, 1);
            chk($sformatf("st%0d_sy", i), SY, 0);
            chk($sformatf("st%0d_data", i), memdata, 8'(8'h80 + i));
        end
        req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00); step();
        chk("st_end_vx", VX, 0);

        // ignored write while full
        SX = 1'b1;
        req(1'b1, 1'b1, 1'b0, 8'h02, 8'h00); step();
        req(1'b1, 1'b1, 1'b0, 8'h01, 8'h00); step();
        chk("full_sy", SY, 1);
        req(1'b1, 1'b0, 1'b1, 8'h30, 8'hFF); step();
        chk("ign_sy", SY, 1);
        chk("ign_data", memdata, 8'h32);

        // reset mid-stream with count=2, SX=1; write attempted under reset
        reset = 1'b1;
        req(1'b1, 1'b0, 1'b1, 8'h30, 8'hEE); step();
        chk("mrst_vx", VX, 0);
        chk("mrst_sy", SY, 0);
        chk("mrst_data", memdata, 0);
        reset = 1'b0; SX = 1'b0;
        req(1'b1, 1'b1, 1'b0, 8'h30, 8'h00); step();
        chk("ign_rd30", memdata, 8'h3C);
        req(1'b1, 1'b1, 1'b0, 8'h10, 8'h00); step();
        chk("persist_rd10", memdata, 8'hA5);
        req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00); step();
        chk("final_vx", VX, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
